// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one byte-wide UART transmitter among NUM_REQ byte-stream
//   requesters. A rotating-priority arbiter picks the owner. Requesters use a
//   valid/ready handshake. The transmitter uses a start/busy/done handshake.
//   A done watchdog frees the owner if the transmitter never reports done.
//
//   Optional feature macro: UART_TX_SCHED_PKT_LOCK_EN
//     defined   - the owner keeps the grant across bytes until i_req_last is
//                 seen or MAX_BURST bytes have been sent (packet lock).
//     undefined - ownership is released after every byte, so arbitration is
//                 strictly per byte and i_req_last is ignored.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 3,
    parameter int MAX_BURST    = 16,
    parameter int DONE_TIMEOUT = 16384
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic                 o_timeout
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W    = $clog2(DONE_TIMEOUT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;        // highest-priority requester for next pick
    logic [IDX_W-1:0]   owner;      // index of the current grant holder
    logic [WD_W-1:0]    wd_cnt;     // cycles spent waiting for i_tx_done
    logic [BURST_W-1:0] burst_cnt;  // bytes sent under the current grant
    logic               last_q;     // i_req_last of the byte just accepted

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   owner_inc;

    // Round-robin pick: first valid requester searching upward from ptr, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // that no path leaves it unassigned, which would infer a latch.
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!pick_found && i_req_valid[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(c);
            end
        end
    end

    // Pointer value used on release: the requester after the owner, modulo NUM_REQ.
    assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

`ifndef UART_TX_SCHED_PKT_LOCK_EN
    // Without packet lock the last flag and burst count have no consumer.
    logic unused_cfg;
    assign unused_cfg = (^{i_req_last, last_q, burst_cnt}) ^ (burst_cnt < BURST_W'(MAX_BURST));
`endif

    // Scheduler FSM. All outputs are registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            wd_cnt      <= '0;
            burst_cnt   <= '0;
            last_q      <= 1'b0;
            o_req_ready <= '0;
            o_grant     <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
            o_timeout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register in
            // this block sees the pre-edge values of the others.
            o_tx_start  <= 1'b0;
            o_req_ready <= '0;
            o_timeout   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        owner   <= pick_idx;
                        o_grant <= NUM_REQ'(1) << pick_idx;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (!i_req_valid[owner]) begin
                        // Owner withdrew: release without sending anything.
                        o_grant   <= '0;
                        ptr       <= owner_inc;
                        burst_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (!i_tx_busy) begin
                        o_tx_start  <= 1'b1;
                        o_req_ready <= NUM_REQ'(1) << owner;
                        o_tx_data   <= i_req_data[{owner, 3'b000} +: 8];
                        last_q      <= i_req_last[owner];
                        burst_cnt   <= burst_cnt + BURST_W'(1);
                        wd_cnt      <= '0;
                        state       <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (i_tx_done) begin
`ifdef UART_TX_SCHED_PKT_LOCK_EN
                        if (!last_q && (burst_cnt < BURST_W'(MAX_BURST))) begin
                            state <= S_ISSUE;
                        end else begin
                            o_grant   <= '0;
                            ptr       <= owner_inc;
                            burst_cnt <= '0;
                            state     <= S_IDLE;
                        end
`else
                        o_grant   <= '0;
                        ptr       <= owner_inc;
                        burst_cnt <= '0;
                        state     <= S_IDLE;
`endif
                    end else if (wd_cnt == WD_W'(DONE_TIMEOUT - 1)) begin
                        // Transmitter hung: abort and hand the line to someone else.
                        o_timeout <= 1'b1;
                        o_grant   <= '0;
                        ptr       <= owner_inc;
                        burst_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
